// File: rtl/sobel_gcd_spi_pkg.sv
// rtl/sobel_gcd_spi_pkg.sv - shared constants and types for both ends of the sobel/gcd SPI link
//   Opcodes understood by the peripheral, the initiator FSM state type and the
//   default payload width used by the master.
package sobel_gcd_spi_pkg;

  localparam logic [7:0] OP_WR_OPERANDS = 8'h01;
  localparam logic [7:0] OP_RD_GCD      = 8'h02;
  localparam logic [7:0] OP_WR_PIXEL    = 8'h03;
  localparam logic [7:0] OP_RD_SOBEL    = 8'h04;

  localparam int DATA_W_DEF = 24;
  localparam int OPCODE_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

endpackage

// File: rtl/sobel_gcd_spi_clkgen.sv
// rtl/sobel_gcd_spi_clkgen.sv - SCK half-period counter with rise/fall strobes
//   i_clk, i_nreset : clock, asynchronous active-low reset
//   i_run           : counter runs while high, held at zero while low
//   i_sck           : current SCK level, selects which strobe a tick becomes
//   o_tick          : last cycle of the current half-period
//   o_rise, o_fall  : o_tick qualified by the SCK level it will toggle from
module sobel_gcd_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_run,
  input  logic i_sck,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = i_run && (r_cnt == HLAST);

  // Held at zero while idle so the first half-period after accept is full length.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_cnt <= '0;
    end else if (!i_run || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_tick;
  assign o_rise = w_tick && !i_sck;
  assign o_fall = w_tick && i_sck;

endmodule

// File: rtl/sobel_gcd_spi_master.sv
// rtl/sobel_gcd_spi_master.sv - SPI mode-0 initiator sending opcode+data frames and returning read data
//   clk_i, nreset_i          : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  : command handshake, ready only in IDLE
//   cmd_opcode_i/cmd_wdata_i : frame contents, opcode shifted out first, MSB first
//   rsp_valid_o/rsp_rdata_o  : one-cycle pulse at frame end, last DATA_W received bits (held)
//   spi_sck_o/spi_cs_o       : serial clock (idle low), chip select (active low)
//   spi_sdo_o/spi_sdi_i      : serial data out / in
module sobel_gcd_spi_master
  import sobel_gcd_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [7:0]        cmd_opcode_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              spi_sck_o,
  output logic              spi_cs_o,
  output logic              spi_sdo_o,
  input  logic              spi_sdi_i
);

  localparam int F  = OPCODE_W + DATA_W;
  localparam int BW = $clog2(F + 1);
  localparam logic [BW-1:0] BLAST = BW'(F - 1);

  spi_state_t        r_state;
  logic [F-1:0]      r_tx;
  logic [F-1:0]      r_rx;
  logic [BW-1:0]     r_bitcnt;
  logic              r_sck;
  logic              r_cs;
  logic              r_sdo;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;

  logic w_run;
  logic w_tick;
  logic w_rise;
  logic w_fall;

  assign w_run = (r_state != ST_IDLE);

  sobel_gcd_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .i_clk    (clk_i),
    .i_nreset (nreset_i),
    .i_run    (w_run),
    .i_sck    (r_sck),
    .o_tick   (w_tick),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state     <= ST_IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_bitcnt    <= '0;
      r_sck       <= 1'b0;
      r_cs        <= 1'b1;
      r_sdo       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            // CS and the first data bit are presented together on the accept edge.
            r_tx     <= {cmd_opcode_i, cmd_wdata_i};
            r_rx     <= '0;
            r_bitcnt <= '0;
            r_cs     <= 1'b0;
            r_sdo    <= cmd_opcode_i[7];
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_rise) begin
            r_sck   <= 1'b1;
            r_rx    <= (r_rx << 1) | F'(spi_sdi_i);
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            r_sck <= 1'b1;
            r_rx  <= (r_rx << 1) | F'(spi_sdi_i);
          end else if (w_fall) begin
            r_sck <= 1'b0;
            if (r_bitcnt == BLAST) begin
              r_sdo   <= 1'b0;
              r_state <= ST_HOLD;
            end else begin
              // r_tx[F-2] is the bit that becomes MSB after this shift.
              r_tx     <= r_tx << 1;
              r_sdo    <= r_tx[F-2];
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cs        <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rdata     <= r_rx[DATA_W-1:0];
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign spi_sck_o   = r_sck;
  assign spi_cs_o    = r_cs;
  assign spi_sdo_o   = r_sdo;

endmodule
